// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the
// loader/debug port; serialises req/ack transactions and absorbs read latency.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  // state | meaning
  // IDLE  | sample requests, grant and latch the winner's fields
  // ISSUE | mem_en strobe for the latched access
  // WAIT  | count out the read latency, capture mem_rdata at the end
  // DONE  | ack pulse to the owner
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state;
  logic       last_owner;
  logic       lat_we;
  logic       grant_ld;
  logic [1:0] cnt;

  // On a tie the port that did not win last time is granted.
  assign grant_ld = ld_req && (!cpu_req || !last_owner);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      cnt        <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req || ld_req) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            owner      <= grant_ld;
            last_owner <= grant_ld;
            lat_we     <= grant_ld ? ld_we : cpu_we;
            mem_addr   <= grant_ld ? ld_addr : cpu_addr;
            mem_wdata  <= grant_ld ? ld_wdata : cpu_wdata;
            mem_en     <= 1'b1;
            mem_we     <= grant_ld ? ld_we : cpu_we;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            state   <= DONE;
            cpu_ack <= !owner;
            ld_ack  <= owner;
          end else begin
            cnt   <= 2'(MEM_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            if (owner) ld_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
            cpu_ack <= !owner;
            ld_ack  <= owner;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=1 (index 0), one with
// MEM_LAT=3 (index 1), a behavioural memory per instance, vectors plus random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        cpu_req   [2];
  logic        cpu_we    [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_wdata [2];
  logic        cpu_ack   [2];
  logic [31:0] cpu_rdata [2];
  logic        ld_req    [2];
  logic        ld_we     [2];
  logic [31:0] ld_addr   [2];
  logic [31:0] ld_wdata  [2];
  logic        ld_ack    [2];
  logic [31:0] ld_rdata  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];
  logic        owner     [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]),
    .ld_req(ld_req[0]), .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .ld_wdata(ld_wdata[0]),
    .ld_ack(ld_ack[0]), .ld_rdata(ld_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0]));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst[1]),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]),
    .ld_req(ld_req[1]), .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .ld_wdata(ld_wdata[1]),
    .ld_ack(ld_ack[1]), .ld_rdata(ld_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1]));

  // Behavioural memory macros: read data valid only in cycle ISSUE+latency.
  logic [31:0] phys0 [logic [31:0]];
  logic [31:0] phys1 [logic [31:0]];
  bit          pend_v [2];
  int          due    [2];
  logic [31:0] pend_a [2];

  function automatic int latof(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] memrd(input int d, input logic [31:0] a);
    if (d == 0) return phys0.exists(a) ? phys0[a] : 32'h0;
    return phys1.exists(a) ? phys1[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] === 1'b1) begin
        pend_v[d] = 1'b1;
        due[d]    = cyc + latof(d);
        pend_a[d] = mem_addr[d];
        if (mem_we[d] === 1'b1) begin
          if (d == 0) phys0[mem_addr[d]] = mem_wdata[d];
          else        phys1[mem_addr[d]] = mem_wdata[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (pend_v[d] && cyc == due[d]) ? memrd(d, pend_a[d]) : 32'hFFFF_FFFF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input bit p, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!p) begin
      cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
    end else begin
      ld_req[d] = req; ld_we[d] = we; ld_addr[d] = addr; ld_wdata[d] = wdata;
    end
  endtask

  function automatic logic ackof(input int d, input bit p);
    return p ? ld_ack[d] : cpu_ack[d];
  endfunction

  function automatic logic [31:0] rdof(input int d, input bit p);
    return p ? ld_rdata[d] : cpu_rdata[d];
  endfunction

  typedef struct {
    int          d;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [8];

  // Single transaction from IDLE; cycle 0 is the cycle the request is first sampled.
  task automatic run_row(input vec_t v, input string tag);
    int          ack_k = -1, en_k = -1, en_n = 0;
    logic [31:0] en_a = '0, en_wd = '0, rd = '0;
    logic        en_we = 1'b0;
    bit          other_ack = 1'b0, owner_bad = 1'b0;
    @(negedge clk);
    drive(v.d, v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 12 && ack_k < 0; k++) begin
      @(posedge clk); #1;
      if (mem_en[v.d]) begin
        en_n++; en_k = k; en_a = mem_addr[v.d]; en_we = mem_we[v.d]; en_wd = mem_wdata[v.d];
      end
      if (busy[v.d] && owner[v.d] != v.port) owner_bad = 1'b1;
      if (ackof(v.d, !v.port)) other_ack = 1'b1;
      if (ackof(v.d, v.port)) begin ack_k = k; rd = rdof(v.d, v.port); end
    end
    @(posedge clk); #1;
    chk({tag, "_ack_pulse"}, 32'(ackof(v.d, v.port)), 32'd0);
    drive(v.d, v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, "_ack_cycle"}, 32'(ack_k), 32'(v.lat));
    chk({tag, "_en_count"}, 32'(en_n), 32'd1);
    chk({tag, "_en_cycle"}, 32'(en_k), 32'd1);
    chk({tag, "_mem_addr"}, en_a, v.addr);
    chk({tag, "_mem_we"}, 32'(en_we), 32'(v.we));
    if (v.we) chk({tag, "_mem_wdata"}, en_wd, v.wdata);
    chk({tag, "_rdata"}, rd, v.rdata);
    chk({tag, "_other_ack"}, 32'(other_ack), 32'd0);
    chk({tag, "_owner"}, 32'(owner_bad), 32'd0);
  endtask

  task automatic tie_test();
    int   g = 0, acks = 0;
    int   gk [4] = '{-1, -1, -1, -1};
    logic go [4] = '{1'bx, 1'bx, 1'bx, 1'bx};
    @(posedge clk); #1; rst[0] = 1'b1;
    @(posedge clk); #1; rst[0] = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 1; k <= 30 && acks < 4; k++) begin
      @(posedge clk); #1;
      if (mem_en[0] && g < 4) begin go[g] = owner[0]; gk[g] = k; g++; end
      if (cpu_ack[0] || ld_ack[0]) acks++;
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_owner%0d", i), 32'(go[i]), 32'(i % 2));
      chk($sformatf("tie_issue%0d", i), 32'(gk[i]), 32'(1 + 4 * i));
    end
  endtask

  task automatic b2b_test();
    int          acks = 0, en_n = 0;
    int          ack_k [2] = '{-1, -1};
    int          en_k  [2] = '{-1, -1};
    logic [31:0] en_a  [2] = '{32'h0, 32'h0};
    logic [31:0] rd    [2] = '{32'h0, 32'h0};
    bit          held_bad = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 16 && acks < 2; k++) begin
      @(posedge clk); #1;
      if (acks == 1 && k == ack_k[0] + 1) drive(0, 1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
      if (mem_en[0]) begin
        if (en_n < 2) begin en_k[en_n] = k; en_a[en_n] = mem_addr[0]; end
        en_n++;
      end
      if (cpu_ack[0]) begin ack_k[acks] = k; rd[acks] = cpu_rdata[0]; acks++; end
      else if (acks == 1 && cpu_rdata[0] !== 32'hCAFE_F00D) held_bad = 1'b1;
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_ack1_cycle", 32'(ack_k[0]), 32'd3);
    chk("b2b_rdata1", rd[0], 32'hCAFE_F00D);
    chk("b2b_en2_cycle", 32'(en_k[1]), 32'd5);
    chk("b2b_en2_addr", en_a[1], 32'h14);
    chk("b2b_ack2_cycle", 32'(ack_k[1]), 32'd7);
    chk("b2b_rdata2", rd[1], 32'h1111_2222);
    chk("b2b_rdata_held", 32'(held_bad), 32'd0);
    chk("b2b_en_count", 32'(en_n), 32'd2);
  endtask

  task automatic reset_mid_read();
    bit   any_ack = 1'b0;
    vec_t v;
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk("rstmid_busy_before", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("rstmid_busy", 32'(busy[1]), 32'd0);
    chk("rstmid_cpu_rdata", cpu_rdata[1], 32'h0);
    chk("rstmid_ld_rdata", ld_rdata[1], 32'h0);
    chk("rstmid_mem_addr", mem_addr[1], 32'h0);
    repeat (6) begin
      @(posedge clk); #1;
      if (cpu_ack[1] || ld_ack[1] || mem_en[1]) any_ack = 1'b1;
    end
    chk("rstmid_no_ack", 32'(any_ack), 32'd0);
    v = '{1, 1'b0, 1'b0, 32'h20, 32'h0, 5, 32'hA5A5_A5A5};
    run_row(v, "rstmid_after");
  endtask

  // Reference state for random traffic: memory contents in completion order,
  // last read value per port, and completed-transaction counts per port.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_rd [2];
  int          acks_n  [2];

  task automatic rand_port(input int d, input bit p);
    bit          we, got;
    logic [31:0] addr, wdata, rd, exp_rd, en_a;
    int          gap, start, en_n, en_c;
    @(posedge clk); #1;
    for (int i = 0; i < 25; i++) begin
      we    = 1'($urandom_range(0, 1));
      addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      wdata = $urandom;
      gap   = $urandom_range(0, 2);
      if (gap > 0) begin
        drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (gap) begin @(posedge clk); #1; end
      end
      drive(d, p, 1'b1, we, addr, wdata);
      start = acks_n[!p];
      en_n = 0; en_c = -100; en_a = '0; got = 1'b0; rd = '0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(posedge clk); #1;
        if (mem_en[d] && owner[d] == p) begin en_n++; en_c = cyc; en_a = mem_addr[d]; end
        if (ackof(d, p)) begin got = 1'b1; rd = rdof(d, p); end
      end
      if (!got) begin
        chk($sformatf("rand%0d_p%0d_timeout", d, p), 32'd0, 32'd1);
        break;
      end
      acks_n[p]++;
      chk($sformatf("rand%0d_p%0d_en_count", d, p), 32'(en_n), 32'd1);
      chk($sformatf("rand%0d_p%0d_addr", d, p), en_a, addr);
      chk($sformatf("rand%0d_p%0d_latency", d, p), 32'(cyc - en_c),
          we ? 32'd1 : 32'(1 + latof(d)));
      chk($sformatf("rand%0d_p%0d_fair", d, p), 32'(acks_n[!p] - start <= 1), 32'd1);
      if (we) begin
        chk($sformatf("rand%0d_p%0d_rdata_kept", d, p), rd, last_rd[p]);
        ref_mem[addr] = wdata;
      end else begin
        exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : 32'h0;
        chk($sformatf("rand%0d_p%0d_rdata", d, p), rd, exp_rd);
        last_rd[p] = exp_rd;
      end
      @(posedge clk); #1;
    end
    drive(d, p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(d, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      mem_rdata[d] = 32'hFFFF_FFFF;
      pend_v[d] = 1'b0;
      due[d] = -1;
      pend_a[d] = 32'h0;
    end
    phys0[32'h10] = 32'hDEAD_BEEF;
    phys0[32'h14] = 32'h1111_2222;
    phys1[32'h20] = 32'hA5A5_A5A5;

    tbl[0] = '{0, 1'b0, 1'b0, 32'h10, 32'h0,         3, 32'hDEAD_BEEF};
    tbl[1] = '{0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 2, 32'h0};
    tbl[2] = '{0, 1'b1, 1'b0, 32'h40, 32'h0,         3, 32'h1234_5678};
    tbl[3] = '{0, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 2, 32'hDEAD_BEEF};
    tbl[4] = '{0, 1'b0, 1'b0, 32'h10, 32'h0,         3, 32'hCAFE_F00D};
    tbl[5] = '{1, 1'b0, 1'b0, 32'h20, 32'h0,         5, 32'hA5A5_A5A5};
    tbl[6] = '{1, 1'b1, 1'b1, 32'h24, 32'h0BAD_BEEF, 2, 32'h0};
    tbl[7] = '{1, 1'b1, 1'b0, 32'h24, 32'h0,         5, 32'h0BAD_BEEF};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d_cpu_ack", d), 32'(cpu_ack[d]), 32'd0);
      chk($sformatf("reset%0d_ld_ack", d), 32'(ld_ack[d]), 32'd0);
      chk($sformatf("reset%0d_mem_en", d), 32'(mem_en[d]), 32'd0);
      chk($sformatf("reset%0d_mem_we", d), 32'(mem_we[d]), 32'd0);
      chk($sformatf("reset%0d_mem_addr", d), mem_addr[d], 32'h0);
      chk($sformatf("reset%0d_mem_wdata", d), mem_wdata[d], 32'h0);
      chk($sformatf("reset%0d_cpu_rdata", d), cpu_rdata[d], 32'h0);
      chk($sformatf("reset%0d_ld_rdata", d), ld_rdata[d], 32'h0);
      chk($sformatf("reset%0d_busy", d), 32'(busy[d]), 32'd0);
      chk($sformatf("reset%0d_owner", d), 32'(owner[d]), 32'd0);
      rst[d] = 1'b0;
    end

    for (int i = 0; i < 8; i++) run_row(tbl[i], $sformatf("vec%0d", i));

    tie_test();
    b2b_test();
    reset_mid_read();

    for (int d = 0; d < 2; d++) begin
      @(posedge clk); #1; rst[d] = 1'b1;
      @(posedge clk); #1; rst[d] = 1'b0;
      ref_mem.delete();
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
      acks_n[0] = 0; acks_n[1] = 0;
      fork
        rand_port(d, 1'b0);
        rand_port(d, 1'b1);
      join
      repeat (8) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
